// File: rtl/test_phy_pkg.sv
// -----------------------------------------------------------------------------
// test_phy_pkg
// Shared definitions for the PHY receive-path frame checker:
//   - rx_state_e        : checker state (IDLE / DATA)
//   - DEFAULT_FRAME_LEN : default frame length in bytes (sof..eof inclusive)
//   - CRC32_*           : Ethernet CRC-32 polynomial, init value and the
//                         residue left in the register after data + FCS
//   - crc32_byte()      : one byte of CRC-32 update, data consumed LSB first
// -----------------------------------------------------------------------------
package test_phy_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } rx_state_e;

    localparam int          DEFAULT_FRAME_LEN = 64;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    // MSB-first shift register fed with the byte LSB first. This is the
    // bit-reversed twin of the usual reflected Ethernet CRC, which is why the
    // good-frame residue is 0xC704DD7B rather than 0xDEBB20E3.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/test_phy_rx_checker_crc32_d8.sv
// -----------------------------------------------------------------------------
// crc32_d8
// Byte-wide combinational CRC-32 update (polynomial 0x04C11DB7).
// Ports:
//   crc_in  [31:0] in   current CRC register value
//   data    [7:0]  in   byte to fold in (bit 0 is the first bit on the wire)
//   crc_out [31:0] out  updated CRC register value
// -----------------------------------------------------------------------------
module crc32_d8
    import test_phy_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    assign crc_out = crc32_byte(crc_in, data);

endmodule

// File: rtl/test_phy_rx_checker.sv
// -----------------------------------------------------------------------------
// test_phy_rx_checker
// Checks test frames arriving on a byte-wide MAC receive stream. Byte 0 of a
// frame is a sequence number S, byte i carries (S + i) mod 256. Each frame gets
// exactly one one-cycle verdict pulse (good or error) one cycle after its eof
// beat, or one cycle after a sof beat that aborts it.
//
// Build option: define TEST_PHY_RX_CHECKER_FCS_EN to treat the last 4 bytes as
// an Ethernet CRC-32 FCS (LSB first) instead of pattern bytes.
//
// Parameters:
//   FRAME_LEN  bytes per frame, sof through eof inclusive (8..1024)
//   CNT_W      width of the saturating frame counters
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous reset, active low
//   mac_rx_data     in   received byte
//   mac_rx_valid    in   byte qualifier (low = stall)
//   mac_rx_sof      in   first byte of frame (with valid)
//   mac_rx_eof      in   last byte of frame (with valid)
//   clr_cnt         in   synchronous clear of counters, err and sequence sync
//   mac_rx_fr_good  out  one-cycle good-frame pulse
//   mac_rx_fr_err   out  one-cycle bad-frame pulse
//   err             out  sticky error flag
//   good_cnt        out  saturating good-frame count
//   err_cnt         out  saturating bad-frame count
// -----------------------------------------------------------------------------
module test_phy_rx_checker
    import test_phy_pkg::*;
#(
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       mac_rx_data,
    input  logic             mac_rx_valid,
    input  logic             mac_rx_sof,
    input  logic             mac_rx_eof,
    input  logic             clr_cnt,
    output logic             mac_rx_fr_good,
    output logic             mac_rx_fr_err,
    output logic             err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // Byte counter holds up to FRAME_LEN+1; kept at least 8 bits wide so its
    // low byte can be used directly as the pattern offset.
    localparam int BCNT_W = ($clog2(FRAME_LEN + 2) > 8) ? $clog2(FRAME_LEN + 2) : 8;
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(FRAME_LEN + 1);
    localparam logic [BCNT_W-1:0] BCNT_EOF = BCNT_W'(FRAME_LEN - 1);

`ifdef TEST_PHY_RX_CHECKER_FCS_EN
    localparam logic [BCNT_W-1:0] PAT_LEN = BCNT_W'(FRAME_LEN - 4);
`else
    localparam logic [BCNT_W-1:0] PAT_LEN = BCNT_W'(FRAME_LEN);
`endif

    rx_state_e         state;
    logic [BCNT_W-1:0] bcnt;       // bytes of the current frame seen so far
    logic [7:0]        seq_s;      // S of the frame in progress
    logic [7:0]        last_s;     // S of the most recent frame
    logic              synced;     // last_s is a valid sequence reference
    logic              frame_bad;  // sequence or pattern error seen so far

    logic [7:0]        exp_byte;
    logic              pat_bad;
    logic              seq_bad;
    logic              fcs_bad;
    logic              verdict_good;
    logic              verdict_err;

`ifdef TEST_PHY_RX_CHECKER_FCS_EN
    logic [31:0] crc_reg;
    logic [31:0] crc_in;
    logic [31:0] crc_next;

    // A sof beat restarts the CRC, so seed from the init value on that beat.
    assign crc_in = mac_rx_sof ? CRC32_INIT : crc_reg;

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc_in),
        .data    (mac_rx_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_reg <= CRC32_INIT;
        end else if (mac_rx_valid && (mac_rx_sof || state == DATA)) begin
            crc_reg <= crc_next;
        end
    end

    // Running the CRC over data plus a correct FCS leaves the fixed residue.
    assign fcs_bad = (crc_next != CRC32_RESIDUE);
`else
    assign fcs_bad = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        exp_byte     = seq_s + bcnt[7:0];
        pat_bad      = (bcnt < PAT_LEN) && (mac_rx_data != exp_byte);
        seq_bad      = synced && (mac_rx_data != last_s + 8'd1);
        verdict_good = 1'b0;
        verdict_err  = 1'b0;

        if (mac_rx_valid) begin
            if (mac_rx_sof) begin
                // Aborting a frame in progress, or a 1-byte sof+eof frame.
                if (state == DATA || mac_rx_eof) begin
                    verdict_err = 1'b1;
                end
            end else if (state == DATA && mac_rx_eof) begin
                if (frame_bad || pat_bad || fcs_bad || bcnt != BCNT_EOF) begin
                    verdict_err = 1'b1;
                end else begin
                    verdict_good = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            bcnt           <= '0;
            seq_s          <= '0;
            last_s         <= '0;
            synced         <= 1'b0;
            frame_bad      <= 1'b0;
            mac_rx_fr_good <= 1'b0;
            mac_rx_fr_err  <= 1'b0;
            err            <= 1'b0;
            good_cnt       <= '0;
            err_cnt        <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; a later assignment to
            // the same register in this block (clr_cnt below) wins the cycle.
            mac_rx_fr_good <= verdict_good;
            mac_rx_fr_err  <= verdict_err;

            if (mac_rx_valid) begin
                if (mac_rx_sof) begin
                    seq_s     <= mac_rx_data;
                    last_s    <= mac_rx_data;
                    synced    <= 1'b1;
                    frame_bad <= seq_bad;
                    bcnt      <= BCNT_W'(1);
                    state     <= mac_rx_eof ? IDLE : DATA;
                end else if (state == DATA) begin
                    if (bcnt != BCNT_MAX) begin
                        bcnt <= bcnt + BCNT_W'(1);
                    end
                    if (pat_bad) begin
                        frame_bad <= 1'b1;
                    end
                    if (mac_rx_eof) begin
                        state <= IDLE;
                    end
                end
            end

            if (clr_cnt) begin
                good_cnt <= '0;
                err_cnt  <= '0;
                err      <= 1'b0;
                synced   <= 1'b0;
            end else begin
                if (verdict_good && good_cnt != '1) begin
                    good_cnt <= good_cnt + CNT_W'(1);
                end
                if (verdict_err) begin
                    err <= 1'b1;
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_test_phy_rx_checker.sv
module tb_test_phy_rx_checker;

    localparam int FL   = 64;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef TEST_PHY_RX_CHECKER_FCS_EN
    localparam bit FCS = 1'b1;
    localparam int PL  = FL - 4;
`else
    localparam bit FCS = 1'b0;
    localparam int PL  = FL;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          valid = 1'b0;
    logic          sof = 1'b0;
    logic          eof = 1'b0;
    logic          clr = 1'b0;
    logic          fr_good;
    logic          fr_err;
    logic          err;
    logic [CW-1:0] good_cnt;
    logic [CW-1:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Pulse monitor and expected pulse totals (never cleared).
    int mon_g = 0;
    int mon_e = 0;
    int exp_g = 0;
    int exp_e = 0;

    // Reference model state.
    int         m_good = 0;
    int         m_err = 0;
    bit         m_flag = 1'b0;
    bit         m_synced = 1'b0;
    bit         m_in_frame = 1'b0;
    logic [7:0] m_last = 8'h00;

    test_phy_rx_checker #(
        .FRAME_LEN (FL),
        .CNT_W     (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mac_rx_data    (data),
        .mac_rx_valid   (valid),
        .mac_rx_sof     (sof),
        .mac_rx_eof     (eof),
        .clr_cnt        (clr),
        .mac_rx_fr_good (fr_good),
        .mac_rx_fr_err  (fr_err),
        .err            (err),
        .good_cnt       (good_cnt),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fr_good === 1'b1) mon_g++;
        if (fr_err === 1'b1)  mon_e++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reflected Ethernet CRC-32 over the first n bytes; returns the FCS value.
    function automatic logic [31:0] ref_fcs(input logic [7:0] b[$], input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic model_verdict(input bit g, input bit clr_now);
        if (g) exp_g++; else exp_e++;
        if (clr_now) begin
            m_good = 0; m_err = 0; m_flag = 1'b0; m_synced = 1'b0;
        end else if (g) begin
            if (m_good < CMAX) m_good++;
        end else begin
            if (m_err < CMAX) m_err++;
            m_flag = 1'b1;
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_good_cnt"}, 32'(good_cnt), 32'(m_good));
        check({tag, "_err_cnt"},  32'(err_cnt),  32'(m_err));
        check({tag, "_err"},      32'(err),      32'(m_flag));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0; sof = 1'b0; eof = 1'b0; clr = 1'b0;
        end
    endtask

    task automatic check_totals(input string tag);
        idle(2);
        check({tag, "_good_pulses"}, 32'(mon_g), 32'(exp_g));
        check({tag, "_err_pulses"},  32'(mon_e), 32'(exp_e));
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        valid = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_good = 0; m_err = 0; m_flag = 1'b0; m_synced = 1'b0;
        check_counters("clr");
    endtask

    // Send one frame of len bytes starting with S=s. bad_idx>=1 corrupts that
    // byte; complete=0 stops without eof (the next sof aborts it).
    task automatic send_frame(input logic [7:0] s, input int len, input int bad_idx,
                              input int gap_max, input bit complete,
                              input bit fcs_flip, input bit clr_on_eof);
        logic [7:0]  q[$];
        logic [31:0] c;
        bit          seq_ok, good, aborting, corrupt;
        int          ngap;

        for (int i = 0; i < len; i++) q.push_back(8'(int'(s) + i));
        corrupt = (bad_idx >= 1) && (bad_idx < len);
        if (corrupt) q[bad_idx] = (q[bad_idx] == 8'h00) ? 8'hFF : 8'h00;
        if (FCS && len == FL) begin
            c = ref_fcs(q, FL - 4);
            for (int k = 0; k < 4; k++) q[FL-4+k] = 8'(c >> (8 * k));
            if (fcs_flip) q[FL-2] = q[FL-2] ^ 8'h10;
        end

        aborting = m_in_frame;
        seq_ok   = !m_synced || (s == 8'(m_last + 8'd1));
        m_last   = s;
        m_synced = 1'b1;
        good     = complete && seq_ok && (len == FL) && !corrupt && !fcs_flip;
        if (aborting) model_verdict(1'b0, 1'b0);

        @(negedge clk);
        valid = 1'b1; sof = 1'b1; eof = (len == 1); data = q[0];
        clr   = clr_on_eof && (len == 1);
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            if (i == 1 && aborting) begin
                check("abort_fr_err",  32'(fr_err),  32'd1);
                check("abort_fr_good", 32'(fr_good), 32'd0);
            end
            ngap = $urandom_range(0, gap_max);
            repeat (ngap) begin
                valid = 1'b0; sof = 1'b0; eof = 1'b0; clr = 1'b0;
                @(negedge clk);
            end
            valid = 1'b1; sof = 1'b0; data = q[i];
            eof   = complete && (i == len - 1);
            clr   = clr_on_eof && eof;
        end

        @(negedge clk);
        valid = 1'b0; sof = 1'b0; eof = 1'b0; clr = 1'b0;
        if (complete) begin
            model_verdict(good, clr_on_eof);
            check("verdict_good", 32'(fr_good), 32'(good));
            check("verdict_err",  32'(fr_err),  32'(!good));
            check_counters("frame");
            m_in_frame = 1'b0;
        end else begin
            m_in_frame = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] s;
        int         len;
        int         bad;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_fr_good",  32'(fr_good),  32'd0);
        check("rst_fr_err",   32'(fr_err),   32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_good_cnt", 32'(good_cnt), 32'd0);
        check("rst_err_cnt",  32'(err_cnt),  32'd0);
        rst = 1'b1;
        idle(2);

        // Three back-to-back good frames.
        send_frame(8'h10, FL, 0, 0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h11, FL, 0, 0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h12, FL, 0, 0, 1'b1, 1'b0, 1'b0);
        check("three_good_cnt", 32'(good_cnt), 32'd3);
        check("three_err",      32'(err),      32'd0);
        check_totals("three");

        // Corrupted payload byte 20.
        pulse_clr();
        send_frame(8'h05, FL, 20, 0, 1'b1, 1'b0, 1'b0);
        check("corrupt_err_cnt", 32'(err_cnt), 32'd1);

        // Length errors: short, long, single sof+eof beat.
        send_frame(8'h06, FL - 1, 0, 0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h07, FL + 1, 0, 0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h08, 1,      0, 0, 1'b1, 1'b0, 1'b0);
        check("len_err_cnt", 32'(err_cnt), 32'd4);
        check_totals("len");

        // Abort by a second sof at byte 30, then a full frame.
        send_frame(8'h09, 30, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(3);
        send_frame(8'h0A, FL, 0, 0, 1'b1, 1'b0, 1'b0);
        check_totals("abort");

        // Sequence error with stalls, then clear.
        pulse_clr();
        send_frame(8'h01, FL, 0, 5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h03, FL, 0, 5, 1'b1, 1'b0, 1'b0);
        check("seq_good_cnt", 32'(good_cnt), 32'd1);
        check("seq_err_cnt",  32'(err_cnt),  32'd1);
        pulse_clr();

        // Randomized frames against the model.
        for (int n = 0; n < 10; n++) begin
            s   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(m_last + 8'd1);
            len = FL + $urandom_range(0, 4) - 2;
            if ($urandom_range(0, 1) == 0) len = FL;
            bad = ($urandom_range(0, 2) == 0) ? $urandom_range(1, PL - 1) : 0;
            send_frame(s, len, bad, 3, 1'b1, 1'b0, 1'b0);
        end
        check_totals("random");

        // Beats in IDLE without sof give no verdict.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            valid = 1'b1; sof = 1'b0; eof = (k == 3); data = 8'($urandom);
        end
        check_totals("idle_junk");

        // clr_cnt on the eof beat: verdict still pulses, counters cleared.
        send_frame(8'(m_last + 8'd1), FL, 0, 0, 1'b1, 1'b0, 1'b0);
        send_frame(8'(m_last + 8'd1), FL, 0, 0, 1'b1, 1'b0, 1'b1);
        check_totals("clr_eof");

`ifdef TEST_PHY_RX_CHECKER_FCS_EN
        // Flipped FCS bit, then a correct FCS.
        send_frame(8'(m_last + 8'd1), FL, 0, 0, 1'b1, 1'b1, 1'b0);
        send_frame(8'(m_last + 8'd1), FL, 0, 0, 1'b1, 1'b0, 1'b0);
        check_totals("fcs");
`endif

        // Reset mid-frame discards it with no verdict.
        send_frame(8'h40, 25, 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        #1;
        check("midrst_fr_err",   32'(fr_err),   32'd0);
        check("midrst_good_cnt", 32'(good_cnt), 32'd0);
        check("midrst_err_cnt",  32'(err_cnt),  32'd0);
        check("midrst_err",      32'(err),      32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_good = 0; m_err = 0; m_flag = 1'b0; m_synced = 1'b0; m_in_frame = 1'b0;
        check_totals("midrst");
        send_frame(8'h77, FL, 0, 0, 1'b1, 1'b0, 1'b0);

        // Counter saturation.
        for (int k = 0; k < CMAX + 2; k++) send_frame(8'(m_last + 8'd1), FL, 0, 0, 1'b1, 1'b0, 1'b0);
        check("sat_good_cnt", 32'(good_cnt), 32'(CMAX));
        for (int k = 0; k < CMAX + 2; k++) send_frame(8'(m_last + 8'd1), 1, 0, 0, 1'b1, 1'b0, 1'b0);
        check("sat_err_cnt", 32'(err_cnt), 32'(CMAX));
        check_totals("sat");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
